conv_core_ctrl: RTL

Sequencer for the parallel-row 3x3 convolution core. It accepts a frame start plus image width, then:
- triggers the kernel buffer load;
- steps the kernel selector and accumulator controls three cycles per input column;
- drains the TOTAL_UNITS partial sums out of the T chain on a valid/ready output handshake.

It sits between the input row-stream DMA and the convolution core; the core's control inputs are driven only by this block.

---
 rtl/conv_core_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/conv_core_ctrl.sv
// conv_core_ctrl
// ---------------------------------------------------------------------------
// Sequencer for the parallel-row 3x3 convolution core. On an accepted frame
// start it strobes the kernel buffer load. It then walks the kernel column
// select through L/M/R for every input column. Once three columns are in, it
// drains the TOTAL_UNITS partial sums out of the T chain after every column.
//
// Optional feature macro: CONV_CTRL_STALL_CNT_EN
//   When defined, adds a 32-bit stall_cnt output. It counts MAC cycles
//   starved by s_valid=0 plus SHIFT cycles back-pressured by m_ready=0.
//
// Ports
//   clk, rstn      clock, asynchronous active-low reset
//   start          frame start pulse, sampled only in IDLE
//   cfg_cols       image width in columns, latched on accepted start
//   s_valid        input column word present on core x_in
//   s_ready        input column word consumed this cycle
//   m_ready        downstream accepts T_out this cycle
//   m_valid        T_out holds a result word
//   m_last         final result word of the frame
//   buff_en        kernel buffer capture strobe
//   kernel_sel     kernel column select (0 L, 1 M, 2 R)
//   A_sel          accumulator phase (mirrors kernel_sel in MAC)
//   MA_en          multiply-accumulate enable
//   dv_in          data valid to core
//   T_en           T-chain register enable
//   T_sel          0 = load partial sum, 1 = shift chain toward T_out
//   busy           high in any state but IDLE
//   done           one-cycle pulse at frame end
//   cfg_err        one-cycle pulse when start is rejected (cfg_cols < 3)
//   stall_cnt      stall cycle counter (only with CONV_CTRL_STALL_CNT_EN)
//   fsm_state      current sequencer state, for observation
//
// Handshake: a word moves on a cycle where both valid and ready are high.
// On the input side, s_valid is the producer's valid. s_ready marks the
// cycle in which the column word is consumed: the third MAC phase with
// s_valid high. On the output side, m_valid stays high without dropping
// until m_ready is seen. Every cycle with m_valid & m_ready is one
// delivered beat.
// ---------------------------------------------------------------------------
module conv_core_ctrl #(
    parameter int TOTAL_UNITS = 8,
    parameter int COL_W       = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [COL_W-1:0] cfg_cols,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             m_ready,
    output logic             m_valid,
    output logic             m_last,
    output logic             buff_en,
    output logic [1:0]       kernel_sel,
    output logic [1:0]       A_sel,
    output logic             MA_en,
    output logic             dv_in,
    output logic             T_en,
    output logic             T_sel,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
`ifdef CONV_CTRL_STALL_CNT_EN
    output logic [31:0]      stall_cnt,
`endif
    output logic [2:0]       fsm_state
);

    localparam int BW = (TOTAL_UNITS > 1) ? $clog2(TOTAL_UNITS) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(TOTAL_UNITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_K = 3'd1,
        S_MAC    = 3'd2,
        S_SHIFT  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state;
    logic [COL_W-1:0] cols_lat;
    logic [COL_W-1:0] col;       // number of completed input columns
    logic [1:0]       phase;
    logic [BW-1:0]    beat;
    logic             cfg_ok;
    logic             in_mac;
    logic             in_shift;
    logic             col_end;

    assign cfg_ok   = (cfg_cols >= COL_W'(3));
    assign in_mac   = (state == S_MAC);
    assign in_shift = (state == S_SHIFT);
    assign col_end  = in_mac && s_valid && (phase == 2'd2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            cols_lat <= '0;
            col      <= '0;
            phase    <= '0;
            beat     <= '0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            cols_lat <= cfg_cols;
                            col      <= '0;
                            phase    <= '0;
                            beat     <= '0;
                            state    <= S_LOAD_K;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_LOAD_K: state <= S_MAC;
                S_MAC: begin
                    if (s_valid) begin
                        if (phase == 2'd2) begin
                            phase <= '0;
                            col   <= col + COL_W'(1);
                            // A 3-wide window is complete once the
                            // column with index 2 or later has been consumed.
                            if (col >= COL_W'(2)) state <= S_SHIFT;
                        end else begin
                            phase <= phase + 2'd1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (m_ready) begin
                        if (beat == BEAT_LAST) begin
                            beat  <= '0;
                            state <= (col == cols_lat) ? S_DONE : S_MAC;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CONV_CTRL_STALL_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if ((state == S_IDLE) && start && cfg_ok) begin
            stall_cnt <= '0;
        end else if ((in_mac && !s_valid) || (in_shift && !m_ready)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

    // Core controls: everything is decoded from state/counters except the
    // s_valid / m_ready qualified enables.
    assign dv_in      = in_mac && s_valid;
    assign MA_en      = in_mac && s_valid;
    assign kernel_sel = in_mac ? phase : 2'd0;
    assign A_sel      = in_mac ? phase : 2'd0;
    assign s_ready    = col_end;
    assign T_en       = col_end || (in_shift && m_ready);
    assign T_sel      = in_shift;
    assign m_valid    = in_shift;
    assign m_last     = in_shift && (beat == BEAT_LAST) && (col == cols_lat);
    assign buff_en    = (state == S_LOAD_K);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign fsm_state  = state;

endmodule
